fifo_uart_tx: RTL and testbench

Downstream consumer of the 8-deep, 8-bit synchronous FIFO. It pops bytes through the FIFO's rd/empty/data_out interface and serializes each one as a UART 8N1 frame on a single tx line. The FIFO has a one-cycle registered read latency, which this block accounts for. The block sits between the FIFO and the chip pad/serial link.

---
 rtl/fifo_uart_tx_pkg.sv | 20 ++
 rtl/fifo_uart_tx_if.sv | 21 ++
 rtl/fifo_uart_tx_baud_tick_gen.sv | 30 +++
 rtl/fifo_uart_tx.sv | 127 ++++++++++++
 tb/tb_fifo_uart_tx.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_uart_tx_pkg.sv
// fifo_uart_tx shared types and constants.
// Optional macro FIFO_UART_TX_PARITY_EN adds the PARITY state (8E1 frames).
package fifo_uart_tx_pkg;

    localparam int   DATA_BITS  = 8;
    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LOAD,
        START,
        DATA,
`ifdef FIFO_UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read-side bundle between the FIFO and fifo_uart_tx.
// master: the consumer issuing reads; slave: the FIFO itself.
interface fifo_uart_tx_if;

    logic                                  fifo_rd;
    logic                                  fifo_empty;
    logic [fifo_uart_tx_pkg::DATA_BITS-1:0] fifo_data;

    modport master (
        output fifo_rd,
        input  fifo_empty,
        input  fifo_data
    );

    modport slave (
        input  fifo_rd,
        output fifo_empty,
        output fifo_data
    );

endinterface

// File: rtl/fifo_uart_tx_baud_tick_gen.sv
// Baud counter: counts 0..CLKS_PER_BIT-1, tick on terminal count.
// clear restarts the count so each FSM state gets a full bit period.
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == TERM);

    // Free-running bit-period counter, restarted on clear or wrap
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO-fed UART transmitter: pops a byte, sends it as 8N1 on tx.
// FIFO_UART_TX_PARITY_EN defined: even parity bit added (8E1).
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           enable,
    fifo_uart_tx_if.master fifo,
    output logic           tx,
    output logic           busy,
    output logic           frame_done
);

    localparam int BW = $clog2(DATA_BITS);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    state_t                 state, state_n;
    logic [BW-1:0]          bit_q, bit_n;
    logic [DATA_BITS-1:0]   data_q, data_n;
    logic                   tx_n;
    logic                   clear;
    logic                   tick;

    // Restart the bit period whenever the FSM changes state
    assign clear = (state_n != state);

    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .tick  (tick)
    );

    assign busy       = (state != IDLE);
    assign frame_done = (state == STOP) && tick;

    // Next-state, bit index and shift data selection
    always_comb begin
        state_n = state;
        bit_n   = bit_q;
        data_n  = data_q;
        unique case (state)
            IDLE: begin
                if (enable && !fifo.fifo_empty) begin
                    state_n = POP;
                end
            end
            POP: begin
                state_n = LOAD;
            end
            LOAD: begin
                data_n  = fifo.fifo_data;
                state_n = START;
            end
            START: begin
                if (tick) begin
                    state_n = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_q == LAST_BIT) begin
                        bit_n = '0;
`ifdef FIFO_UART_TX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end else begin
                        bit_n = bit_q + BW'(1);
                    end
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_n = STOP;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Line level for the upcoming cycle, so tx can be registered
    always_comb begin
        tx_n = IDLE_LEVEL;
        unique case (state_n)
            START:  tx_n = 1'b0;
            DATA:   tx_n = data_n[bit_n];
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: tx_n = ^data_n;
`endif
            default: tx_n = IDLE_LEVEL;
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            bit_q        <= '0;
            data_q       <= '0;
            tx           <= IDLE_LEVEL;
            fifo.fifo_rd <= 1'b0;
        end else begin
            state        <= state_n;
            bit_q        <= bit_n;
            data_q       <= data_n;
            tx           <= tx_n;
            fifo.fifo_rd <= (state_n == POP);
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Testbench for fifo_uart_tx with a small registered-read FIFO model.
// Build with FIFO_UART_TX_PARITY_EN defined to exercise 8E1 frames.
module tb_fifo_uart_tx;

    localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic tx;
    logic busy;
    logic frame_done;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem [0:63];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int rd_cnt = 0;
    int rd_double = 0;
    int underflow = 0;
    logic rd_prev = 1'b0;
    logic [15:0] samp;

    fifo_uart_tx_if fif();

    assign fif.fifo_empty = (wr_ptr == rd_ptr);

    fifo_uart_tx #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .fifo       (fif),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // FIFO model: one-cycle registered read latency
    always @(posedge clk) begin
        rd_prev <= fif.fifo_rd;
        if (fif.fifo_rd) begin
            rd_cnt <= rd_cnt + 1;
            if (rd_prev) rd_double <= rd_double + 1;
            if (wr_ptr == rd_ptr) begin
                underflow <= underflow + 1;
            end else begin
                fif.fifo_data <= mem[rd_ptr[5:0]];
                rd_ptr <= rd_ptr + 1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic push(input logic [7:0] b);
        mem[wr_ptr[5:0]] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    function automatic logic fbit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef FIFO_UART_TX_PARITY_EN
        if (k == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic check_frame(input logic [7:0] b, input string nm,
                               input int drop_at, input int rst_at);
        int w;
        int bad;
        int fdbad;
        int bsybad;
        w = 0;
        while (tx !== 1'b0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (w >= 200) begin
            errors++;
            $display("FAIL %s start: tx=%b want 0 within 200 cycles", nm, tx);
            return;
        end
        bad = 0;
        fdbad = 0;
        bsybad = 0;
        samp = '1;
        for (int i = 0; i < NB * CPB; i++) begin
            if (i == rst_at) begin
                rst_n = 1'b0;
                @(negedge clk);
                checks++;
                if ({tx, busy, frame_done} !== 3'b100) begin
                    errors++;
                    $display("FAIL %s reset: tx/busy/done=%b want 100",
                             nm, {tx, busy, frame_done});
                end
                rst_n = 1'b1;
                return;
            end
            if (i == drop_at) enable = 1'b0;
            if (i % CPB == 1) samp[i/CPB] = tx;
            if (tx !== fbit(b, i / CPB)) bad++;
            if (frame_done !== (i == NB * CPB - 1)) fdbad++;
            if (busy !== 1'b1) bsybad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s bits: %0d wrong tx cycles want 0", nm, bad);
        end
        checks++;
        if (fdbad != 0) begin
            errors++;
            $display("FAIL %s frame_done: %0d wrong cycles want 0", nm, fdbad);
        end
        checks++;
        if (bsybad != 0) begin
            errors++;
            $display("FAIL %s busy: %0d low cycles want 0", nm, bsybad);
        end
        checks++;
        if ({tx, busy} !== 2'b10) begin
            errors++;
            $display("FAIL %s end: tx/busy=%b want 10", nm, {tx, busy});
        end
    endtask

    task automatic measure_gap(input string nm);
        int g;
        g = 0;
        while (tx === 1'b1 && g < 20) begin
            g++;
            @(negedge clk);
        end
        checks++;
        if (g != 3) begin
            errors++;
            $display("FAIL %s gap: %0d idle cycles want 3", nm, g);
        end
    endtask

    task automatic test_reset();
        enable = 1'b1;
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if ({tx, fif.fifo_rd, busy, frame_done} !== 4'b1000) begin
                errors++;
                $display("FAIL reset cyc%0d: tx/rd/busy/done=%b want 1000",
                         i, {tx, fif.fifo_rd, busy, frame_done});
            end
            if (i == 2) rst_n = 1'b1;
        end
    endtask

    task automatic test_single();
        int r0;
        r0 = rd_cnt;
        push(8'hA5);
        check_frame(8'hA5, "single", -1, -1);
        checks++;
        if (rd_cnt - r0 != 1 || rd_double != 0) begin
            errors++;
            $display("FAIL single rd: pops=%0d double=%0d want 1 0",
                     rd_cnt - r0, rd_double);
        end
        checks++;
        if (samp[8:0] !== 9'b101001010) begin
            errors++;
            $display("FAIL single pattern: %b want 101001010", samp[8:0]);
        end
    endtask

    task automatic test_back_to_back();
        int r0;
        r0 = rd_cnt;
        push(8'h01);
        push(8'hFF);
        push(8'h80);
        check_frame(8'h01, "b2b0", -1, -1);
        measure_gap("b2b01");
        check_frame(8'hFF, "b2b1", -1, -1);
        measure_gap("b2b12");
        check_frame(8'h80, "b2b2", -1, -1);
        checks++;
        if (rd_cnt - r0 != 3) begin
            errors++;
            $display("FAIL b2b pops: %0d want 3", rd_cnt - r0);
        end
        checks++;
        if (underflow != 0 || rd_double != 0) begin
            errors++;
            $display("FAIL b2b empty: underflow=%0d double=%0d want 0 0",
                     underflow, rd_double);
        end
    endtask

    task automatic test_enable_drop();
        int r0;
        int txbad;
        push(8'h3C);
        push(8'h11);
        check_frame(8'h3C, "endrop", 4 * CPB, -1);
        r0 = rd_cnt;
        txbad = 0;
        repeat (20) begin
            @(negedge clk);
            if (tx !== 1'b1) txbad++;
        end
        checks++;
        if (rd_cnt != r0 || txbad != 0) begin
            errors++;
            $display("FAIL endrop hold: pops=%0d txlow=%0d want 0 0",
                     rd_cnt - r0, txbad);
        end
        checks++;
        if (fif.fifo_empty !== 1'b0) begin
            errors++;
            $display("FAIL endrop fifo: empty=%b want 0", fif.fifo_empty);
        end
        enable = 1'b1;
        check_frame(8'h11, "resume", -1, -1);
    endtask

    task automatic test_reset_mid();
        int r0;
        push(8'h5A);
        push(8'hC3);
        check_frame(8'h5A, "rstmid", -1, 6 * CPB);
        r0 = rd_cnt;
        check_frame(8'hC3, "postrst", -1, -1);
        checks++;
        if (rd_cnt - r0 != 1) begin
            errors++;
            $display("FAIL postrst pops: %0d want 1", rd_cnt - r0);
        end
    endtask

`ifdef FIFO_UART_TX_PARITY_EN
    task automatic test_parity();
        push(8'hA5);
        check_frame(8'hA5, "parA5", -1, -1);
        checks++;
        if (samp[9] !== 1'b0) begin
            errors++;
            $display("FAIL parA5 parity: %b want 0", samp[9]);
        end
        push(8'h07);
        check_frame(8'h07, "par07", -1, -1);
        checks++;
        if (samp[9] !== 1'b1) begin
            errors++;
            $display("FAIL par07 parity: %b want 1", samp[9]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_enable_drop();
        test_reset_mid();
`ifdef FIFO_UART_TX_PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
